mmio_bridge_ctrl: RTL and testbench
===================================

// Module: mmio_bridge_ctrl
// PURPOSE
// - Sequences core MMIO load/store requests onto the H2F Avalon-MM bridge (7-seg, UART peripherals).
// - Sits between the core memory stage and the bridge master port. One transaction in flight at a time.
// - Decodes the bridge window and rejects misaligned or out-of-window accesses without touching the bus.
// - Enforces a bus timeout so a hung peripheral cannot stall the core forever.
// PARAMETERS
// - BASE_ADDR     32'hFC00_0000  bridge window base (H2F_BASE)
// - WINDOW_BYTES  32'h0000_0100  window size in bytes, power of two
// - TIMEOUT_CYC   256            max cycles spent in REQ+WAIT_RD before an error response
// PORTS
// - clk            in   1   system clock; everything is on the rising edge
// - rst_n          in   1   asynchronous, active-low reset
// - req_valid      in   1   core request valid
// - req_ready      out  1   controller can accept a request
// - req_we         in   1   1 = store, 0 = load
// - req_addr       in   32  absolute byte address
// - req_wdata      in   32  store data
// - req_be         in   4   byte enables
// - resp_valid     out  1   response valid, held until accepted
// - resp_ready     in   1   core accepts the response
// - resp_rdata     out  32  load data; 0 for stores and errors
// - resp_err       out  1   1 = misaligned, out-of-window or timeout
// - avm_address    out  32  offset from BASE_ADDR (req_addr - BASE_ADDR)
// - avm_read       out  1   Avalon read strobe
// - avm_write      out  1   Avalon write strobe
// - avm_writedata  out  32  write data
// - avm_byteenable out  4   byte enables
// - avm_waitrequest in  1   slave stall
// - avm_readdata   in   32  read data
// - avm_readdatavalid in 1  read data valid
// BEHAVIOUR
// - Reset (async on rst_n low): state = IDLE, timeout counter = 0; all outputs 0 except req_ready = 1.
// - Reset mid-transaction drops the bus command immediately (strobes go to 0 asynchronously).
// - Four states: IDLE, REQ, WAIT_RD, RESP.
// - IDLE:
//   - req_ready = 1.
//   - On req_valid, capture addr/wdata/be/we.
//   - If addr[1:0] != 0, or addr is outside [BASE_ADDR, BASE_ADDR + WINDOW_BYTES): go to RESP with err = 1. No strobe is issued.
//   - Otherwise go to REQ.
// - REQ:
//   - avm_read or avm_write = 1, with address, data and byteenable stable.
//   - Hold the strobe while avm_waitrequest = 1.
//   - On the first cycle with waitrequest = 0:
//     - Write: go to RESP with err = 0.
//     - Read: go to WAIT_RD. Strobes go low on the next cycle.
// - WAIT_RD:
//   - On avm_readdatavalid, register avm_readdata into resp_rdata and go to RESP with err = 0.
//   - If readdatavalid and waitrequest = 0 arrive in the same REQ cycle, that data is taken directly and WAIT_RD is skipped.
// - Timeout:
//   - The counter clears on entering REQ and increments each cycle in REQ or WAIT_RD.
//   - When it reaches TIMEOUT_CYC - 1, go to RESP with err = 1 and rdata = 0, and drop the strobe the next cycle.
// - RESP:
//   - resp_valid = 1, with rdata and err stable.
//   - When resp_ready = 1, go to IDLE.
//   - req_ready = 0 in every state other than IDLE. There are no back-to-back accepts, so throughput is at most 1 request every 3 cycles.
// - Stray avm_readdatavalid outside WAIT_RD/REQ is ignored (for example, late data after a timeout).
// - Latency, with the request accepted in cycle N and zero-wait-state slaves:
//   - Write: strobe in N+1, resp_valid in N+2.
//   - Read: the same when readdatavalid comes with the accept; one cycle more per cycle of read latency.
// - Address arithmetic is 32-bit unsigned. The window check uses (addr - BASE_ADDR) < WINDOW_BYTES, so addresses below base wrap and fail the check.
// STRUCTURE
// - Add to pref_defines: mmio_state_t enum {IDLE, REQ, WAIT_RD, RESP}; MMIO_WINDOW_BYTES; MMIO_TIMEOUT_CYC.
// - Reuse H2F_BASE from pref_defines as the default for BASE_ADDR.
// - One natural sub-module, mmio_timeout_cnt: a clear/enable counter of width $clog2(TIMEOUT_CYC) with a terminal-count flag.
// - Everything else is a single FSM plus capture registers.
// TESTING
// 1. Write 0x0000_0005 to 0xFC00_0004, waitrequest = 0 -> avm_write for 1 cycle, avm_address = 0x4, be = 4'hF; resp_valid next cycle, err = 0.
// 2. Read 0xFC00_0000, waitrequest = 1 for 3 cycles, readdatavalid 2 cycles later with 0x41 -> strobe held 4 cycles; resp_rdata = 0x41, err = 0.
// 3. Read 0xFC00_0002 (misaligned) and read 0xFB00_0000 (out of window) -> no avm strobe ever; resp_err = 1, rdata = 0.
// 4. Keep waitrequest = 1 forever -> resp_err = 1 exactly TIMEOUT_CYC cycles after entering REQ; a later stray readdatavalid is ignored and the next read completes normally.
// 5. Hold resp_ready = 0 for 5 cycles -> resp_valid, rdata and err stable, req_ready = 0 throughout; accept completes on the 6th cycle.
// 6. Assert rst_n = 0 during REQ -> avm_read/avm_write = 0 and req_ready = 1 without waiting for a clock edge; after release, state is IDLE.

Source files
------------

// File: rtl/mmio_bridge_ctrl_pkg.sv
// Shared definitions for the MMIO bridge controller: window/timeout defaults and FSM state type.
package mmio_bridge_ctrl_pkg;

  localparam logic [31:0] H2F_BASE          = 32'hFC00_0000;
  localparam logic [31:0] MMIO_WINDOW_BYTES = 32'h0000_0100;
  localparam int          MMIO_TIMEOUT_CYC  = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } mmio_state_t;

  // Word-aligned and inside [base, base + window); addresses below base wrap and fail.
  function automatic logic mmio_addr_ok(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] window);
    logic [31:0] offset;
    offset = addr - base;
    return (addr[1:0] == 2'b00) && (offset < window);
  endfunction

endpackage

// File: rtl/mmio_timeout_cnt.sv
// Clear/enable cycle counter with a terminal-count flag at TIMEOUT_CYC - 1.
module mmio_timeout_cnt #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign tc = en && (cnt_reg == LAST);

endmodule

// File: rtl/mmio_bridge_ctrl.sv
// Sequences single core MMIO loads/stores onto the H2F Avalon-MM bridge,
// rejecting misaligned/out-of-window accesses and timing out hung slaves.
module mmio_bridge_ctrl
  import mmio_bridge_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = H2F_BASE,
  parameter logic [31:0] WINDOW_BYTES = MMIO_WINDOW_BYTES,
  parameter int          TIMEOUT_CYC  = MMIO_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  mmio_state_t state_reg, state_next;

  logic        we_reg;
  logic [31:0] offset_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic        req_bad;
  logic        cnt_en;
  logic        cnt_tc;

  assign req_bad = !mmio_addr_ok(req_addr, BASE_ADDR, WINDOW_BYTES);
  assign cnt_en  = (state_reg == REQ) || (state_reg == WAIT_RD);

  mmio_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!cnt_en),
    .en   (cnt_en),
    .tc   (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A completing handshake wins over a timeout landing in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = req_bad ? RESP : REQ;
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          state_next = (we_reg || avm_readdatavalid) ? RESP : WAIT_RD;
        end else if (cnt_tc) begin
          state_next = RESP;
        end
      end
      WAIT_RD: begin
        if (avm_readdatavalid || cnt_tc) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg     <= 1'b0;
      offset_reg <= '0;
      wdata_reg  <= '0;
      be_reg     <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg     <= req_we;
            offset_reg <= req_addr - BASE_ADDR;
            wdata_reg  <= req_wdata;
            be_reg     <= req_be;
            rdata_reg  <= '0;
            err_reg    <= req_bad;
          end
        end
        REQ: begin
          if (!avm_waitrequest) begin
            if (!we_reg && avm_readdatavalid) begin
              rdata_reg <= avm_readdata;
            end
          end else if (cnt_tc) begin
            err_reg <= 1'b1;
          end
        end
        WAIT_RD: begin
          if (avm_readdatavalid) begin
            rdata_reg <= avm_readdata;
          end else if (cnt_tc) begin
            err_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign req_ready      = (state_reg == IDLE);
  assign resp_valid     = (state_reg == RESP);
  assign resp_rdata     = rdata_reg;
  assign resp_err       = err_reg;
  assign avm_read       = (state_reg == REQ) && !we_reg;
  assign avm_write      = (state_reg == REQ) && we_reg;
  assign avm_address    = offset_reg;
  assign avm_writedata  = wdata_reg;
  assign avm_byteenable = be_reg;

endmodule

// File: tb/tb_mmio_bridge_ctrl.sv
// Directed bench for mmio_bridge_ctrl with hand-computed expectations.
module tb_mmio_bridge_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_bridge_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_be           (req_be),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    step();
    req_valid = 1'b0;
    $display("issued %s addr=%h wdata=%h be=%h", we ? "write" : "read", addr, wdata, be);
  endtask

  task automatic accept();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  int bad;

  initial begin
    rst_n             = 1'b0;
    req_valid         = 1'b0;
    req_we            = 1'b0;
    req_addr          = '0;
    req_wdata         = '0;
    req_be            = '0;
    resp_ready        = 1'b0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;

    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_avm_read", avm_read, 0);
    chk("rst_avm_write", avm_write, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // 1: zero-wait write
    issue(1'b1, 32'hFC00_0004, 32'h0000_0005, 4'hF);
    chk("wr_strobe", avm_write, 1);
    chk("wr_no_read", avm_read, 0);
    chk("wr_addr", avm_address, 32'h4);
    chk("wr_data", avm_writedata, 32'h5);
    chk("wr_be", avm_byteenable, 4'hF);
    chk("wr_req_ready", req_ready, 0);
    step();
    chk("wr_strobe_drop", avm_write, 0);
    chk("wr_resp_valid", resp_valid, 1);
    chk("wr_resp_err", resp_err, 0);
    chk("wr_resp_rdata", resp_rdata, 0);
    accept();
    chk("wr_back_idle", req_ready, 1);
    chk("wr_resp_clear", resp_valid, 0);

    // 2: read with 3 wait states, data 2 cycles after the accept
    avm_waitrequest = 1'b1;
    issue(1'b0, 32'hFC00_0000, 32'h0, 4'hF);
    chk("rd_addr", avm_address, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("rd_strobe_wait", avm_read, 1);
      step();
    end
    avm_waitrequest = 1'b0;
    chk("rd_strobe_4th", avm_read, 1);
    step();
    chk("rd_strobe_drop", avm_read, 0);
    chk("rd_wait_no_resp", resp_valid, 0);
    step();
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'h41;
    step();
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    chk("rd_resp_valid", resp_valid, 1);
    chk("rd_resp_rdata", resp_rdata, 32'h41);
    chk("rd_resp_err", resp_err, 0);
    accept();

    // 3: rejected accesses never strobe the bus
    issue(1'b0, 32'hFC00_0002, 32'h0, 4'hF);
    chk("mis_no_strobe", avm_read | avm_write, 0);
    chk("mis_resp_valid", resp_valid, 1);
    chk("mis_err", resp_err, 1);
    chk("mis_rdata", resp_rdata, 0);
    accept();
    issue(1'b0, 32'hFB00_0000, 32'h0, 4'hF);
    chk("oow_no_strobe", avm_read | avm_write, 0);
    chk("oow_resp_valid", resp_valid, 1);
    chk("oow_err", resp_err, 1);
    accept();
    issue(1'b1, 32'hFC00_0100, 32'h1, 4'hF);
    chk("edge_out_no_strobe", avm_read | avm_write, 0);
    chk("edge_out_err", resp_err, 1);
    accept();
    // last word of the window, data arrives with the accept: WAIT_RD skipped
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'hDEAD_BEEF;
    issue(1'b0, 32'hFC00_00FC, 32'h0, 4'hF);
    chk("edge_in_strobe", avm_read, 1);
    chk("edge_in_addr", avm_address, 32'hFC);
    step();
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    chk("edge_in_resp_valid", resp_valid, 1);
    chk("edge_in_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("edge_in_err", resp_err, 0);
    accept();

    // 4: hung slave times out 256 cycles after entering REQ
    avm_waitrequest = 1'b1;
    issue(1'b0, 32'hFC00_0008, 32'h0, 4'hF);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (avm_read !== 1'b1 || resp_valid !== 1'b0) bad++;
      step();
    end
    chk("to_strobe_held", bad, 0);
    chk("to_resp_valid", resp_valid, 1);
    chk("to_err", resp_err, 1);
    chk("to_rdata", resp_rdata, 0);
    chk("to_strobe_drop", avm_read, 0);
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'h99;
    step();
    chk("stray_resp_rdata", resp_rdata, 0);
    chk("stray_resp_err", resp_err, 1);
    avm_readdatavalid = 1'b0;
    accept();
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'h77;
    step();
    avm_readdatavalid = 1'b0;
    chk("stray_idle_no_resp", resp_valid, 0);
    issue(1'b0, 32'hFC00_000C, 32'h0, 4'hF);
    chk("after_to_strobe", avm_read, 1);
    step();
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'h1234;
    step();
    avm_readdatavalid = 1'b0;
    chk("after_to_rdata", resp_rdata, 32'h1234);
    chk("after_to_err", resp_err, 0);
    accept();

    // 5: response backpressure
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'hCAFE;
    issue(1'b0, 32'hFC00_0010, 32'h0, 4'h3);
    chk("bp_be", avm_byteenable, 4'h3);
    step();
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE || resp_err !== 1'b0 ||
          req_ready !== 1'b0) bad++;
      step();
    end
    chk("bp_stable", bad, 0);
    chk("bp_6th_valid", resp_valid, 1);
    accept();
    chk("bp_done_ready", req_ready, 1);
    chk("bp_done_valid", resp_valid, 0);

    // 6: async reset during REQ
    avm_waitrequest = 1'b1;
    issue(1'b0, 32'hFC00_0014, 32'h0, 4'hF);
    chk("ar_strobe_before", avm_read, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_read_low", avm_read, 0);
    chk("ar_write_low", avm_write, 0);
    chk("ar_req_ready", req_ready, 1);
    step();
    rst_n = 1'b1;
    avm_waitrequest = 1'b0;
    step();
    chk("ar_idle_ready", req_ready, 1);
    chk("ar_idle_no_resp", resp_valid, 0);
    chk("ar_idle_no_strobe", avm_read | avm_write, 0);
    issue(1'b1, 32'hFC00_0018, 32'hA5A5_A5A5, 4'hC);
    chk("ar_post_write", avm_write, 1);
    chk("ar_post_addr", avm_address, 32'h18);
    step();
    chk("ar_post_resp", resp_valid, 1);
    accept();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
